// File: rtl/output_writer_mmap_pkg.sv
// Shared types and constants for the mmap output writer AXI4 write master.
package output_writer_mmap_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam int         ADDR_4K      = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } state_t;

    function automatic int log2_int(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_writer_mmap_m_axi_fifo.sv
// Small FIFO holding (beats-1) of each issued AW burst until its W beats are sent.
module output_writer_mmap_m_axi_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW + 1)'(DEPTH));

endmodule

// File: rtl/output_writer_mmap_m_axi_write.sv
// AXI4 write master for one HLS mmap output: splits a request into bursts,
// forwards the HLS beat stream as W and folds all B responses into one HLS response.
//   state    | meaning
//   IDLE     | ready for an HLS write request
//   ISSUE    | issuing AW bursts until the request is fully covered
//   DRAIN    | all AWs issued, waiting for outstanding B responses
//   RESP     | presenting the HLS write response
module output_writer_mmap_m_axi_write
    import output_writer_mmap_pkg::*;
#(
    parameter int         BUS_ADDR_WIDTH         = 64,
    parameter int         BUS_DATA_WIDTH         = 512,
    parameter int         NUM_WRITE_OUTSTANDING  = 4,
    parameter int         MAX_WRITE_BURST_LENGTH = 16,
    parameter logic [3:0] C_CACHE_VALUE          = 4'b0011
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ACLK_EN,
    output logic [BUS_ADDR_WIDTH-1:0]     out_BUS_AWADDR,
    output logic [7:0]                    out_BUS_AWLEN,
    output logic [0:0]                    out_BUS_AWID,
    output logic [2:0]                    out_BUS_AWSIZE,
    output logic [1:0]                    out_BUS_AWBURST,
    output logic                          out_BUS_AWLOCK,
    output logic [3:0]                    out_BUS_AWCACHE,
    output logic [2:0]                    out_BUS_AWPROT,
    output logic [3:0]                    out_BUS_AWQOS,
    output logic [3:0]                    out_BUS_AWREGION,
    output logic                          out_BUS_AWVALID,
    input  logic                          in_BUS_AWREADY,
    output logic [BUS_DATA_WIDTH-1:0]     out_BUS_WDATA,
    output logic [BUS_DATA_WIDTH/8-1:0]   out_BUS_WSTRB,
    output logic                          out_BUS_WLAST,
    output logic                          out_BUS_WVALID,
    input  logic                          in_BUS_WREADY,
    input  logic [1:0]                    in_BUS_BRESP,
    input  logic                          in_BUS_BVALID,
    output logic                          out_BUS_BREADY,
    input  logic [BUS_ADDR_WIDTH-1:0]     in_HLS_AWADDR,
    input  logic [31:0]                   in_HLS_AWLEN,
    input  logic                          in_HLS_AWVALID,
    output logic                          out_HLS_AWREADY,
    input  logic [BUS_DATA_WIDTH-1:0]     in_HLS_WDATA,
    input  logic [BUS_DATA_WIDTH/8-1:0]   in_HLS_WSTRB,
    input  logic                          in_HLS_WVALID,
    output logic                          out_HLS_WREADY,
    output logic                          out_HLS_BVALID,
    output logic [1:0]                    out_HLS_BRESP,
    input  logic                          in_HLS_BREADY
);
    localparam int BYTES = BUS_DATA_WIDTH / 8;
    localparam int SIZE  = log2_int(BYTES);
    localparam int OW    = log2_int(NUM_WRITE_OUTSTANDING) + 1;

    state_t                    state;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [32:0]               remaining;
    logic [32:0]               burst;
    logic [32:0]               burst_m1;
    logic [12:0]               bytes_to_4k;
    logic [12:0]               beats_to_4k;
    logic                      err;
    logic                      aw_valid;
    logic                      hls_awready;
    logic                      hls_bvalid;
    logic [1:0]                hls_bresp;
    logic                      bready;
    logic [OW-1:0]             outstanding;
    logic [7:0]                w_cnt;
    logic [7:0]                fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      b_hs;
    logic                      w_last;
    logic                      can_issue;
    logic                      unused_bits;

    // Bursts never cross a 4KB page; addr_q is always beat aligned.
    assign bytes_to_4k = 13'(ADDR_4K) - {1'b0, addr_q[11:0]};
    assign beats_to_4k = bytes_to_4k >> SIZE;

    always_comb begin
        burst = remaining;
        if (burst > 33'(MAX_WRITE_BURST_LENGTH)) burst = 33'(MAX_WRITE_BURST_LENGTH);
        if (burst > {20'b0, beats_to_4k})        burst = {20'b0, beats_to_4k};
    end

    assign burst_m1    = burst - 33'd1;
    assign unused_bits = ^burst_m1[32:8];

    assign aw_hs     = aw_valid & in_BUS_AWREADY;
    assign b_hs      = in_BUS_BVALID & bready;
    assign w_hs      = out_BUS_WVALID & in_BUS_WREADY;
    assign w_last    = (w_cnt == fifo_head);
    assign can_issue = (outstanding < OW'(NUM_WRITE_OUTSTANDING)) && !fifo_full;

    output_writer_mmap_m_axi_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (NUM_WRITE_OUTSTANDING)
    ) u_len_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .push      (aw_hs & ACLK_EN),
        .push_data (burst_m1[7:0]),
        .pop       (w_hs & w_last & ACLK_EN),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            err         <= 1'b0;
            aw_valid    <= 1'b0;
            hls_awready <= 1'b0;
            hls_bvalid  <= 1'b0;
            hls_bresp   <= BRESP_OKAY;
            bready      <= 1'b0;
            outstanding <= '0;
            w_cnt       <= '0;
        end else if (ACLK_EN) begin
            if (aw_hs && !b_hs)      outstanding <= outstanding + 1'b1;
            else if (!aw_hs && b_hs) outstanding <= outstanding - 1'b1;
            if (b_hs && in_BUS_BRESP != BRESP_OKAY) err <= 1'b1;
            if (w_hs) w_cnt <= w_last ? 8'd0 : w_cnt + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (hls_awready && in_HLS_AWVALID) begin
                        hls_awready <= 1'b0;
                        addr_q      <= in_HLS_AWADDR & ~(BUS_ADDR_WIDTH'(BYTES - 1));
                        remaining   <= {1'b0, in_HLS_AWLEN} + 33'd1;
                        err         <= 1'b0;
                        bready      <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        hls_awready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (aw_hs) begin
                        addr_q    <= addr_q + (BUS_ADDR_WIDTH'(burst[8:0]) << SIZE);
                        remaining <= remaining - burst;
                        aw_valid  <= 1'b0;
                        if (remaining == burst) state <= ST_DRAIN;
                    end else if (!aw_valid && can_issue) begin
                        aw_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding == '0) begin
                        bready     <= 1'b0;
                        hls_bvalid <= 1'b1;
                        hls_bresp  <= err ? BRESP_SLVERR : BRESP_OKAY;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (in_HLS_BREADY) begin
                        hls_bvalid  <= 1'b0;
                        hls_awready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_BUS_AWADDR   = addr_q;
    assign out_BUS_AWLEN    = burst_m1[7:0];
    assign out_BUS_AWVALID  = aw_valid;
    assign out_BUS_AWID     = 1'b0;
    assign out_BUS_AWSIZE   = 3'(SIZE);
    assign out_BUS_AWBURST  = 2'b01;
    assign out_BUS_AWLOCK   = 1'b0;
    assign out_BUS_AWCACHE  = C_CACHE_VALUE;
    assign out_BUS_AWPROT   = 3'b000;
    assign out_BUS_AWQOS    = 4'b0000;
    assign out_BUS_AWREGION = 4'b0000;

    assign out_BUS_WDATA   = in_HLS_WDATA;
    assign out_BUS_WSTRB   = in_HLS_WSTRB;
    assign out_BUS_WLAST   = w_last;
    assign out_BUS_WVALID  = in_HLS_WVALID & ~fifo_empty;
    assign out_HLS_WREADY  = in_BUS_WREADY & ~fifo_empty;
    assign out_BUS_BREADY  = bready;
    assign out_HLS_AWREADY = hls_awready;
    assign out_HLS_BVALID  = hls_bvalid;
    assign out_HLS_BRESP   = hls_bresp;

endmodule

// File: tb/tb_output_writer_mmap_m_axi_write.sv
// Directed bench for the mmap output writer: burst split, 4KB rule, outstanding limit,
// error folding, random backpressure with clock-enable gaps, and mid-request reset.
module tb_output_writer_mmap_m_axi_write;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         ACLK_EN = 1'b1;
    logic [63:0]  out_BUS_AWADDR;
    logic [7:0]   out_BUS_AWLEN;
    logic [0:0]   out_BUS_AWID;
    logic [2:0]   out_BUS_AWSIZE;
    logic [1:0]   out_BUS_AWBURST;
    logic         out_BUS_AWLOCK;
    logic [3:0]   out_BUS_AWCACHE;
    logic [2:0]   out_BUS_AWPROT;
    logic [3:0]   out_BUS_AWQOS;
    logic [3:0]   out_BUS_AWREGION;
    logic         out_BUS_AWVALID;
    logic         in_BUS_AWREADY = 1'b0;
    logic [511:0] out_BUS_WDATA;
    logic [63:0]  out_BUS_WSTRB;
    logic         out_BUS_WLAST;
    logic         out_BUS_WVALID;
    logic         in_BUS_WREADY = 1'b0;
    logic [1:0]   in_BUS_BRESP = 2'b00;
    logic         in_BUS_BVALID = 1'b0;
    logic         out_BUS_BREADY;
    logic [63:0]  in_HLS_AWADDR = '0;
    logic [31:0]  in_HLS_AWLEN = '0;
    logic         in_HLS_AWVALID = 1'b0;
    logic         out_HLS_AWREADY;
    logic [511:0] in_HLS_WDATA = '0;
    logic [63:0]  in_HLS_WSTRB = '1;
    logic         in_HLS_WVALID = 1'b0;
    logic         out_HLS_WREADY;
    logic         out_HLS_BVALID;
    logic [1:0]   out_HLS_BRESP;
    logic         in_HLS_BREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    output_writer_mmap_m_axi_write #(
        .BUS_ADDR_WIDTH         (64),
        .BUS_DATA_WIDTH         (512),
        .NUM_WRITE_OUTSTANDING  (4),
        .MAX_WRITE_BURST_LENGTH (16),
        .C_CACHE_VALUE          (4'b0011)
    ) dut (
        .ACLK (ACLK), .ARESETN (ARESETN), .ACLK_EN (ACLK_EN),
        .out_BUS_AWADDR (out_BUS_AWADDR), .out_BUS_AWLEN (out_BUS_AWLEN),
        .out_BUS_AWID (out_BUS_AWID), .out_BUS_AWSIZE (out_BUS_AWSIZE),
        .out_BUS_AWBURST (out_BUS_AWBURST), .out_BUS_AWLOCK (out_BUS_AWLOCK),
        .out_BUS_AWCACHE (out_BUS_AWCACHE), .out_BUS_AWPROT (out_BUS_AWPROT),
        .out_BUS_AWQOS (out_BUS_AWQOS), .out_BUS_AWREGION (out_BUS_AWREGION),
        .out_BUS_AWVALID (out_BUS_AWVALID), .in_BUS_AWREADY (in_BUS_AWREADY),
        .out_BUS_WDATA (out_BUS_WDATA), .out_BUS_WSTRB (out_BUS_WSTRB),
        .out_BUS_WLAST (out_BUS_WLAST), .out_BUS_WVALID (out_BUS_WVALID),
        .in_BUS_WREADY (in_BUS_WREADY), .in_BUS_BRESP (in_BUS_BRESP),
        .in_BUS_BVALID (in_BUS_BVALID), .out_BUS_BREADY (out_BUS_BREADY),
        .in_HLS_AWADDR (in_HLS_AWADDR), .in_HLS_AWLEN (in_HLS_AWLEN),
        .in_HLS_AWVALID (in_HLS_AWVALID), .out_HLS_AWREADY (out_HLS_AWREADY),
        .in_HLS_WDATA (in_HLS_WDATA), .in_HLS_WSTRB (in_HLS_WSTRB),
        .in_HLS_WVALID (in_HLS_WVALID), .out_HLS_WREADY (out_HLS_WREADY),
        .out_HLS_BVALID (out_HLS_BVALID), .out_HLS_BRESP (out_HLS_BRESP),
        .in_HLS_BREADY (in_HLS_BREADY)
    );

    int tests = 0;
    int fails = 0;

    // Bus-side observations, recorded at the clock edge where handshakes complete.
    logic [63:0]  aw_addr_q[$];
    logic [7:0]   aw_len_q[$];
    int           aw_cyc_q[$];
    logic [511:0] w_data_q[$];
    logic         w_last_q[$];
    int           b_cyc_q[$];
    logic [1:0]   hls_bresp_q[$];
    int cyc = 0;
    int pending_b = 0;
    int b_total = 0;
    int src_sent = 0;
    int hls_aw_cnt = 0;

    // Stimulus controls owned by the main sequence.
    int src_total = 0;
    bit rnd = 1'b0;
    bit b_enable = 1'b1;
    int slverr_at = -1;

    logic [63:0] ea[$];
    int          el[$];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending_b = 0;
            src_sent  = 0;
        end else begin
            cyc++;
            if (ACLK_EN) begin
                if (out_BUS_AWVALID && in_BUS_AWREADY) begin
                    aw_addr_q.push_back(out_BUS_AWADDR);
                    aw_len_q.push_back(out_BUS_AWLEN);
                    aw_cyc_q.push_back(cyc);
                end
                if (out_BUS_WVALID && in_BUS_WREADY) begin
                    w_data_q.push_back(out_BUS_WDATA);
                    w_last_q.push_back(out_BUS_WLAST);
                    if (out_BUS_WLAST) pending_b++;
                end
                if (in_BUS_BVALID && out_BUS_BREADY) begin
                    pending_b--;
                    b_total++;
                    b_cyc_q.push_back(cyc);
                end
                if (in_HLS_WVALID && out_HLS_WREADY) src_sent++;
                if (in_HLS_AWVALID && out_HLS_AWREADY) hls_aw_cnt++;
                if (out_HLS_BVALID && in_HLS_BREADY) hls_bresp_q.push_back(out_HLS_BRESP);
            end
        end
    end

    always @(negedge ACLK) begin
        ACLK_EN        = rnd ? ($urandom_range(3) != 0) : 1'b1;
        in_BUS_AWREADY = rnd ? 1'($urandom_range(1)) : 1'b1;
        in_BUS_WREADY  = rnd ? 1'($urandom_range(1)) : 1'b1;
        in_BUS_BVALID  = b_enable && (pending_b > 0) && (!rnd || $urandom_range(1) == 1);
        in_BUS_BRESP   = (b_total == slverr_at) ? 2'b10 : 2'b00;
        in_HLS_WVALID  = (src_sent < src_total) && (!rnd || $urandom_range(1) == 1);
        in_HLS_WDATA   = {16{src_sent}};
        in_HLS_BREADY  = rnd ? 1'($urandom_range(1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        aw_addr_q.delete(); aw_len_q.delete(); aw_cyc_q.delete();
        w_data_q.delete(); w_last_q.delete(); b_cyc_q.delete(); hls_bresp_q.delete();
    endtask

    task automatic hls_req(input string tag, input logic [63:0] a, input logic [31:0] l);
        int start;
        int n;
        start = hls_aw_cnt;
        n = 0;
        src_total += int'(l) + 1;
        in_HLS_AWADDR  = a;
        in_HLS_AWLEN   = l;
        in_HLS_AWVALID = 1'b1;
        while (hls_aw_cnt == start && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        in_HLS_AWVALID = 1'b0;
        check({tag, "_hls_aw_accepted"}, 64'(hls_aw_cnt - start), 64'd1);
    endtask

    task automatic wait_resp(input string tag, input logic [1:0] exp);
        int n;
        n = 0;
        while (hls_bresp_q.size() == 0 && n < 5000) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_resp_seen"}, 64'(hls_bresp_q.size()), 64'd1);
        if (hls_bresp_q.size() != 0) check({tag, "_hls_bresp"}, 64'(hls_bresp_q.pop_front()), 64'(exp));
    endtask

    // Compares recorded AWs against ea/el and the W stream against beats base, base+1, ...
    task automatic check_bursts(input string tag, input int base);
        int total;
        int k;
        logic [511:0] d;
        logic [511:0] ed;
        logic         lst;
        total = 0;
        foreach (el[i]) total += el[i] + 1;
        check({tag, "_aw_count"}, 64'(aw_addr_q.size()), 64'(ea.size()));
        check({tag, "_w_count"}, 64'(w_data_q.size()), 64'(total));
        k = 0;
        for (int i = 0; i < ea.size(); i++) begin
            if (aw_addr_q.size() == 0) break;
            check($sformatf("%s_aw%0d_addr", tag, i), aw_addr_q.pop_front(), ea[i]);
            check($sformatf("%s_aw%0d_len", tag, i), 64'(aw_len_q.pop_front()), 64'(el[i]));
            for (int j = 0; j <= el[i]; j++) begin
                if (w_data_q.size() == 0) break;
                d   = w_data_q.pop_front();
                lst = w_last_q.pop_front();
                ed  = {16{32'(base + k)}};
                tests++;
                assert (d === ed) else begin
                    fails++;
                    $error("FAIL %s_wdata%0d: observed %0h expected %0h", tag, k, d[31:0], ed[31:0]);
                end
                check($sformatf("%s_wlast%0d", tag, k), 64'(lst), 64'(j == el[i]));
                k++;
            end
        end
    endtask

    initial begin
        int base;
        bit ok;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_awvalid", 64'(out_BUS_AWVALID), 64'd0);
        check("rst_hls_awready", 64'(out_HLS_AWREADY), 64'd0);
        check("rst_hls_bvalid", 64'(out_HLS_BVALID), 64'd0);
        check("rst_bready", 64'(out_BUS_BREADY), 64'd0);
        check("rst_hls_bresp", 64'(out_HLS_BRESP), 64'd0);
        check("rst_wvalid", 64'(out_BUS_WVALID), 64'd0);
        check("awsize", 64'(out_BUS_AWSIZE), 64'd6);
        check("awcache", 64'(out_BUS_AWCACHE), 64'h3);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("idle_hls_awready", 64'(out_HLS_AWREADY), 64'd1);

        // 1: 40 beats from 0x1000 -> 16/16/8
        clear_q(); base = src_total;
        hls_req("t1", 64'h1000, 32'd39);
        wait_resp("t1", 2'b00);
        ea = '{64'h1000, 64'h1400, 64'h1800}; el = '{15, 15, 7};
        check_bursts("t1", base);

        // 2: 4 beats from 0x0FC0 -> one beat to the 4KB edge, then 3
        clear_q(); base = src_total;
        hls_req("t2", 64'h0FC0, 32'd3);
        wait_resp("t2", 2'b00);
        ea = '{64'h0FC0, 64'h1000}; el = '{0, 2};
        check_bursts("t2", base);

        // 3: B withheld -> only four bursts in flight
        clear_q(); base = src_total;
        b_enable = 1'b0;
        hls_req("t3", 64'h2000, 32'd127);
        repeat (150) @(negedge ACLK);
        check("t3_aw_in_flight", 64'(aw_addr_q.size()), 64'd4);
        check("t3_awvalid_blocked", 64'(out_BUS_AWVALID), 64'd0);
        check("t3_w_beats_sent", 64'(w_data_q.size()), 64'd64);
        b_enable = 1'b1;
        wait_resp("t3", 2'b00);
        ok = (aw_cyc_q.size() > 4) && (b_cyc_q.size() > 0) && (aw_cyc_q[4] > b_cyc_q[0]);
        check("t3_fifth_aw_after_first_b", 64'(ok), 64'd1);
        ea.delete(); el.delete();
        for (int i = 0; i < 8; i++) begin
            ea.push_back(64'h2000 + 64'(i) * 64'h400);
            el.push_back(15);
        end
        check_bursts("t3", base);

        // 4: second of three B responses is SLVERR, then a clean 1-beat request
        clear_q(); base = src_total;
        slverr_at = b_total + 1;
        hls_req("t4", 64'h4000, 32'd47);
        wait_resp("t4", 2'b10);
        slverr_at = -1;
        ea = '{64'h4000, 64'h4400, 64'h4800}; el = '{15, 15, 15};
        check_bursts("t4", base);
        clear_q(); base = src_total;
        hls_req("t4b", 64'h5000, 32'd0);
        wait_resp("t4b", 2'b00);
        ea = '{64'h5000}; el = '{0};
        check_bursts("t4b", base);

        // 5: random backpressure everywhere with clock-enable gaps
        clear_q(); base = src_total;
        rnd = 1'b1;
        hls_req("t5", 64'h6F00, 32'd99);
        wait_resp("t5", 2'b00);
        rnd = 1'b0;
        @(negedge ACLK);
        ea = '{64'h6F00, 64'h7000, 64'h7400, 64'h7800, 64'h7C00, 64'h8000, 64'h8400};
        el = '{3, 15, 15, 15, 15, 15, 15};
        check_bursts("t5", base);

        // 6: reset in the middle of a request, then a fresh request
        clear_q();
        hls_req("t6a", 64'h9000, 32'd63);
        repeat (20) @(negedge ACLK);
        ARESETN = 1'b0;
        src_total = 0;
        @(negedge ACLK);
        check("t6_rst_awvalid", 64'(out_BUS_AWVALID), 64'd0);
        check("t6_rst_hls_awready", 64'(out_HLS_AWREADY), 64'd0);
        check("t6_rst_hls_bvalid", 64'(out_HLS_BVALID), 64'd0);
        check("t6_rst_bready", 64'(out_BUS_BREADY), 64'd0);
        check("t6_rst_wvalid", 64'(out_BUS_WVALID), 64'd0);
        repeat (2) @(negedge ACLK);
        clear_q();
        ARESETN = 1'b1;
        @(negedge ACLK);
        base = src_total;
        hls_req("t6", 64'hA000, 32'd15);
        wait_resp("t6", 2'b00);
        ea = '{64'hA000}; el = '{15};
        check_bursts("t6", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
